cmp_search_sar: RTL and testbench

- Initiator-side controller for the 4-bit magnitude comparator: drives the comparator's `a` operand and consumes its lt/eq/gt flags.
- Binary-searches for the unknown value wired to the comparator's `b` operand and reports it.
- Used for threshold discovery and self-test.
- The comparator stays combinational and external; this block owns all sequencing.

---
 rtl/cmp_search_sar.sv | 141 ++++++++++++++
 tb/tb_cmp_search_sar.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/cmp_search_sar.sv
// Successive-approximation controller that binary-searches the unknown `b` operand of an
// external magnitude comparator. Optional macro CMP_SEARCH_SETTLE_EN adds a settle cycle per compare.
module cmp_search_sar #(
  parameter int WIDTH = 4,
  parameter int PCW   = $clog2(WIDTH + 2)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             cmp_lt,
  input  logic             cmp_eq,
  input  logic             cmp_gt,
  output logic [WIDTH-1:0] trial,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             err,
  output logic [PCW-1:0]   probes
);

  // Handshake: start is a level sampled only in IDLE; done is a one-cycle pulse after the
  // final compare, and result/err/probes stay valid from then until the next accepted start.

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETTLE = 2'd1,
    PROBE  = 2'd2
  } state_t;

  localparam logic [WIDTH:0]   RANGE_MAX = {1'b0, {WIDTH{1'b1}}};
  localparam logic [WIDTH-1:0] TRIAL_MAX = {WIDTH{1'b1}};
  localparam logic [WIDTH-1:0] TRIAL_MID = {1'b0, {(WIDTH-1){1'b1}}};

`ifdef CMP_SEARCH_SETTLE_EN
  localparam state_t COMPARE_ST = SETTLE;
`else
  localparam state_t COMPARE_ST = PROBE;
`endif

  state_t           state, state_n;
  logic [WIDTH:0]   lo, lo_n, hi, hi_n;
  logic [WIDTH:0]   mid_sum;
  logic [WIDTH-1:0] trial_n, result_n;
  logic [PCW-1:0]   probes_n;
  logic             busy_n, done_n, err_n;
  logic             hit, fail;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      lo     <= '0;
      hi     <= RANGE_MAX;
      trial  <= '0;
      result <= '0;
      probes <= '0;
      busy   <= 1'b0;
      done   <= 1'b0;
      err    <= 1'b0;
    end else begin
      state  <= state_n;
      lo     <= lo_n;
      hi     <= hi_n;
      trial  <= trial_n;
      result <= result_n;
      probes <= probes_n;
      busy   <= busy_n;
      done   <= done_n;
      err    <= err_n;
    end
  end

  always_comb begin
    state_n  = state;
    lo_n     = lo;
    hi_n     = hi;
    trial_n  = trial;
    result_n = result;
    probes_n = probes;
    busy_n   = busy;
    done_n   = 1'b0;
    err_n    = err;
    hit      = 1'b0;
    fail     = 1'b0;
    mid_sum  = '0;

    case (state)
      IDLE: begin
        if (start) begin
          lo_n     = '0;
          hi_n     = RANGE_MAX;
          trial_n  = TRIAL_MID;
          busy_n   = 1'b1;
          err_n    = 1'b0;
          probes_n = '0;
          state_n  = COMPARE_ST;
        end
      end

      SETTLE: state_n = PROBE;

      PROBE: begin
        probes_n = probes + 1'b1;
        case ({cmp_lt, cmp_eq, cmp_gt})
          3'b010: hit = 1'b1;
          3'b100: begin
            // A trial already at the top of the range cannot be below the key.
            if (trial == TRIAL_MAX) fail = 1'b1;
            else lo_n = {1'b0, trial} + 1'b1;
          end
          3'b001: begin
            if (trial == '0) fail = 1'b1;
            else hi_n = {1'b0, trial} - 1'b1;
          end
          default: fail = 1'b1;
        endcase

        // An empty window means the flags contradicted earlier answers.
        if (!hit && !fail && (lo_n > hi_n)) fail = 1'b1;

        if (hit) begin
          result_n = trial;
          done_n   = 1'b1;
          busy_n   = 1'b0;
          state_n  = IDLE;
        end else if (fail) begin
          err_n   = 1'b1;
          done_n  = 1'b1;
          busy_n  = 1'b0;
          state_n = IDLE;
        end else begin
          mid_sum = lo_n + hi_n;
          trial_n = mid_sum[WIDTH:1];
          state_n = COMPARE_ST;
        end
      end

      default: state_n = IDLE;
    endcase
  end

endmodule

// File: tb/tb_cmp_search_sar.sv
// Randomized bench for cmp_search_sar: a behavioural comparator drives the flags and a
// high-level binary-search model predicts the trial sequence, result, err and probe count.
module tb_cmp_search_sar;
  localparam int W = 4;
`ifdef CMP_SEARCH_SETTLE_EN
  localparam int CPC = 2;
`else
  localparam int CPC = 1;
`endif

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic         cmp_lt, cmp_eq, cmp_gt;
  logic [W-1:0] trial, result;
  logic         busy, done, err;
  logic [2:0]   probes;

  int key  = 0;
  int mode = 0;  // 0 honest, 1 lt+gt, 2 stuck gt, 3 no flags

  int n_vec = 0;
  int n_bad = 0;
  logic [W-1:0] exp_q[$];
  logic [W-1:0] got_q[$];
  int exp_probes, exp_err;
  int exp_result = 0;

  cmp_search_sar #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n), .start(start),
    .cmp_lt(cmp_lt), .cmp_eq(cmp_eq), .cmp_gt(cmp_gt),
    .trial(trial), .busy(busy), .done(done),
    .result(result), .err(err), .probes(probes)
  );

  always #5 clk = ~clk;

  always_comb begin
    cmp_lt = 1'b0;
    cmp_eq = 1'b0;
    cmp_gt = 1'b0;
    case (mode)
      0: begin
        cmp_lt = (int'(trial) < key);
        cmp_eq = (int'(trial) == key);
        cmp_gt = (int'(trial) > key);
      end
      1: begin
        cmp_lt = 1'b1;
        cmp_gt = 1'b1;
      end
      2: cmp_gt = 1'b1;
      default: ;
    endcase
  end

  task automatic check(input string tag, input int got, input int exp);
    n_vec++;
    if (got != exp) begin
      n_bad++;
      $display("FAIL %s got=%0d exp=%0d (key=%0d mode=%0d)", tag, got, exp, key, mode);
    end
  endtask

  // Reference: search the window [lo,hi] with plain integers, asking the same questions a
  // comparator with the given fault mode would answer.
  task automatic model(input int k, input int m);
    int lo, hi, t, p;
    bit lt, eq, gt;
    exp_q.delete();
    lo = 0;
    hi = (1 << W) - 1;
    p = 0;
    exp_err = 0;
    for (int step = 0; step < 16; step++) begin
      t = (lo + hi) / 2;
      exp_q.push_back(t[W-1:0]);
      p++;
      lt = (m == 0) ? (t < k) : (m == 1);
      eq = (m == 0) ? (t == k) : 1'b0;
      gt = (m == 0) ? (t > k) : (m == 1 || m == 2);
      if ((int'(lt) + int'(eq) + int'(gt)) != 1) begin exp_err = 1; break; end
      if (eq) begin exp_result = t; break; end
      if (lt) begin
        if (t == (1 << W) - 1) begin exp_err = 1; break; end
        lo = t + 1;
      end else begin
        if (t == 0) begin exp_err = 1; break; end
        hi = t - 1;
      end
      if (lo > hi) begin exp_err = 1; break; end
    end
    exp_probes = p;
  endtask

  task automatic run_search(input int k, input int m, input bit issue, input bit hold);
    int  n;
    bit  seen;
    key  = k;
    mode = m;
    model(k, m);
    if (issue) begin
      @(negedge clk);
      start = 1'b1;
    end
    @(posedge clk);
    #1;
    if (!hold) start = 1'b0;
    check("busy_rise", busy, 1);
    check("done_drop", done, 0);
    got_q.delete();
    n = 0;
    seen = 1'b0;
    while (!seen && n < 60) begin
      @(negedge clk);
      n++;
      if (done) seen = 1'b1;
      else if (busy && (got_q.size() == 0 || got_q[$] != trial)) got_q.push_back(trial);
    end
    check("done_seen", seen, 1);
    check("latency", n, exp_probes * CPC + 1);
    check("n_trials", got_q.size(), exp_q.size());
    for (int i = 0; i < got_q.size() && i < exp_q.size(); i++)
      check("trial_seq", got_q[i], exp_q[i]);
    check("result", result, exp_result);
    check("probes", probes, exp_probes);
    check("err", err, exp_err);
    check("busy_end", busy, 0);
    if (!hold) begin
      @(negedge clk);
      check("done_pulse", done, 0);
    end
  endtask

  initial begin
    #12;
    check("rst_trial", trial, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_result", result, 0);
    check("rst_err", err, 0);
    check("rst_probes", probes, 0);
    @(negedge clk);
    rst_n = 1'b1;

    run_search(15, 0, 1'b1, 1'b0);
    run_search(0, 0, 1'b1, 1'b0);
    run_search(6, 0, 1'b1, 1'b0);
    run_search(9, 1, 1'b1, 1'b0);
    run_search(0, 2, 1'b1, 1'b0);
    run_search(11, 3, 1'b1, 1'b0);

    // start held: the second search must be accepted in the done cycle
    run_search(5, 0, 1'b1, 1'b1);
    run_search(5, 0, 1'b0, 1'b0);

    // asynchronous reset in the middle of a search
    key  = 9;
    mode = 0;
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_trial", trial, 0);
    check("arst_busy", busy, 0);
    check("arst_result", result, 0);
    check("arst_probes", probes, 0);
    check("arst_err", err, 0);
    exp_result = 0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("arst_no_done", done, 0);
    end
    rst_n = 1'b1;
    run_search(10, 0, 1'b1, 1'b0);

    for (int i = 0; i < 24; i++) begin
      int m;
      m = $urandom_range(0, 9);
      m = (m < 7) ? 0 : (m - 6);
      run_search($urandom_range(0, (1 << W) - 1), m, 1'b1, 1'b0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
